// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with a req/ack memory handshake,
// upstream stall generation and the MEM/WB pipeline register.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUresult_i,
    input  logic [31:0] Readdata2_i,
    input  logic [4:0]  INS_11_7_i,
    output logic        mem_enable_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic [31:0] ALUresult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  INS_11_7_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic wr_q, wr_d, abort_q, abort_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic wb_rw_q, wb_rw_d, wb_m2r_q, wb_m2r_d;
    logic [31:0] wb_alu_q, wb_alu_d, wb_data_q, wb_data_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic access, go, timeout;
    assign access = MemRead_i | MemWrite_i;
    assign go = access && ALUresult_i[1:0] == 2'b00;
    assign timeout = cnt_q + 8'd1 == TIMEOUT;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? REQ : IDLE;
            REQ:     state_d = mem_ack_i || timeout ? DONE : REQ;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        stall_o = !rst_i && (state_q == REQ || (state_q == IDLE && go));
        mem_enable_o = state_q == REQ;
        cnt_d = '0;
        wr_d = wr_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        err_d = 1'b0;
        wb_rw_d = 1'b0;
        wb_m2r_d = 1'b0;
        wb_alu_d = '0;
        wb_data_d = '0;
        wb_rd_d = '0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    wr_d = MemWrite_i;
                    addr_d = {ALUresult_i[31:2], 2'b00};
                    wdata_d = Readdata2_i;
                    rdata_d = '0;
                    abort_d = 1'b0;
                end else begin
                    // any access reaching here is misaligned and is dropped
                    wb_rw_d = RegWrite_i && !access;
                    wb_m2r_d = MemToReg_i;
                    wb_alu_d = ALUresult_i;
                    wb_rd_d = INS_11_7_i;
                    err_d = access;
                end
            end
            REQ: begin
                cnt_d = mem_ack_i || timeout ? 8'd0 : cnt_q + 8'd1;
                rdata_d = mem_ack_i ? (wr_q ? 32'd0 : mem_data_i) : rdata_q;
                abort_d = !mem_ack_i && timeout;
            end
            default: begin
                wb_rw_d = RegWrite_i && !abort_q;
                wb_m2r_d = MemToReg_i;
                wb_alu_d = ALUresult_i;
                wb_data_d = rdata_q;
                wb_rd_d = INS_11_7_i;
                err_d = abort_q;
            end
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
            err_q <= 1'b0;
            wb_rw_q <= 1'b0;
            wb_m2r_q <= 1'b0;
            wb_alu_q <= '0;
            wb_data_q <= '0;
            wb_rd_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            wr_q <= wr_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            err_q <= err_d;
            wb_rw_q <= wb_rw_d;
            wb_m2r_q <= wb_m2r_d;
            wb_alu_q <= wb_alu_d;
            wb_data_q <= wb_data_d;
            wb_rd_q <= wb_rd_d;
        end
    end
    assign mem_write_o = wr_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = wdata_q;
    assign err_o = err_q;
    assign RegWrite_o = wb_rw_q;
    assign MemToReg_o = wb_m2r_q;
    assign ALUresult_o = wb_alu_q;
    assign ReadData_o = wb_data_q;
    assign INS_11_7_o = wb_rd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed per-cycle vectors; expected outputs are queued
// by the driver and compared by an independent negedge monitor.
module tb_mem_access_unit;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, mem_ack_i;
    logic [31:0] ALUresult_i, Readdata2_i, mem_data_i;
    logic [4:0] INS_11_7_i;
    logic mem_enable_o, mem_write_o, stall_o, err_o, RegWrite_o, MemToReg_o;
    logic [31:0] mem_addr_o, mem_data_o, ALUresult_o, ReadData_o;
    logic [4:0] INS_11_7_o;

    typedef struct packed {
        logic        stall, en, wr;
        logic [31:0] addr, wdata;
        logic        err, rw, m2r;
        logic [31:0] alu, rdat;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    exp_t zero = '0;
    int checks = 0, errors = 0, mon_cyc = 0;

    always #5 clk_i = ~clk_i;

    mem_access_unit #(.ACK_TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALUresult_i(ALUresult_i), .Readdata2_i(Readdata2_i), .INS_11_7_i(INS_11_7_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .stall_o(stall_o), .err_o(err_o),
        .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
        .ALUresult_o(ALUresult_o), .ReadData_o(ReadData_o), .INS_11_7_o(INS_11_7_o)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", n, mon_cyc, a, x);
        end
    endtask

    initial forever begin
        @(negedge clk_i);
        if (q.size() > 0) begin
            exp_t m;
            m = q.pop_front();
            chk("stall_o", 32'(stall_o), 32'(m.stall));
            chk("mem_enable_o", 32'(mem_enable_o), 32'(m.en));
            chk("mem_write_o", 32'(mem_write_o), 32'(m.wr));
            chk("mem_addr_o", mem_addr_o, m.addr);
            chk("mem_data_o", mem_data_o, m.wdata);
            chk("err_o", 32'(err_o), 32'(m.err));
            chk("RegWrite_o", 32'(RegWrite_o), 32'(m.rw));
            chk("MemToReg_o", 32'(MemToReg_o), 32'(m.m2r));
            chk("ALUresult_o", ALUresult_o, m.alu);
            chk("ReadData_o", ReadData_o, m.rdat);
            chk("INS_11_7_o", 32'(INS_11_7_o), 32'(m.rd));
            mon_cyc++;
        end
    end

    function automatic exp_t mk(input logic stall, en, wr, input logic [31:0] addr, wdata,
                                input logic err, rw, m2r, input logic [31:0] alu, rdat,
                                input logic [4:0] rd);
        return '{stall, en, wr, addr, wdata, err, rw, m2r, alu, rdat, rd};
    endfunction

    task automatic ins(input logic rw, m2r, mr, mw, input logic [31:0] alu, wd, input logic [4:0] rd);
        RegWrite_i = rw; MemToReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
        ALUresult_i = alu; Readdata2_i = wd; INS_11_7_i = rd;
    endtask

    task automatic ackd(input logic a, input logic [31:0] d);
        mem_ack_i = a; mem_data_i = d;
    endtask

    task automatic cyc(input exp_t x);
        q.push_back(x);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        ins(0, 0, 0, 0, 0, 0, 0);
        ackd(0, 0);
        @(posedge clk_i);
        #1;
        cyc(zero);
        rst_i = 1'b0;
        cyc(zero);
        // plain ALU op
        ins(1, 0, 0, 0, 32'h10, 0, 5);  cyc(zero);
        ins(0, 0, 0, 0, 0, 0, 0);       cyc(mk(0,0,0, 0,0, 0,1,0, 32'h10,0,5));
        cyc(zero);
        // load 0x100, ack on 3rd REQ cycle
        ins(1, 1, 1, 0, 32'h100, 0, 7); cyc(mk(1,0,0, 0,0, 0,0,0, 0,0,0));
        cyc(mk(1,1,0, 32'h100,0, 0,0,0, 0,0,0));
        cyc(mk(1,1,0, 32'h100,0, 0,0,0, 0,0,0));
        ackd(1, 32'hDEADBEEF);          cyc(mk(1,1,0, 32'h100,0, 0,0,0, 0,0,0));
        ackd(0, 0);                     cyc(mk(0,0,0, 32'h100,0, 0,0,0, 0,0,0));
        ins(0, 0, 0, 0, 0, 0, 0);       cyc(mk(0,0,0, 32'h100,0, 0,1,1, 32'h100,32'hDEADBEEF,7));
        // store 0x12345678 to 0x204, ack on 1st REQ cycle
        ins(0, 0, 0, 1, 32'h204, 32'h12345678, 0); cyc(mk(1,0,0, 32'h100,0, 0,0,0, 0,0,0));
        ackd(1, 32'hFFFFFFFF);          cyc(mk(1,1,1, 32'h204,32'h12345678, 0,0,0, 0,0,0));
        ackd(0, 0);                     cyc(mk(0,0,1, 32'h204,32'h12345678, 0,0,0, 0,0,0));
        ins(0, 0, 0, 0, 0, 0, 0);       cyc(mk(0,0,1, 32'h204,32'h12345678, 0,0,0, 32'h204,0,0));
        cyc(mk(0,0,1, 32'h204,32'h12345678, 0,0,0, 0,0,0));
        // misaligned load
        ins(1, 1, 1, 0, 32'h102, 0, 9); cyc(mk(0,0,1, 32'h204,32'h12345678, 0,0,0, 0,0,0));
        ins(0, 0, 0, 0, 0, 0, 0);       cyc(mk(0,0,1, 32'h204,32'h12345678, 1,0,1, 32'h102,0,9));
        cyc(mk(0,0,1, 32'h204,32'h12345678, 0,0,0, 0,0,0));
        // timeout with ACK_TIMEOUT=4
        ins(1, 1, 1, 0, 32'h300, 0, 3); cyc(mk(1,0,1, 32'h204,32'h12345678, 0,0,0, 0,0,0));
        repeat (4) cyc(mk(1,1,0, 32'h300,0, 0,0,0, 0,0,0));
        cyc(mk(0,0,0, 32'h300,0, 0,0,0, 0,0,0));
        ins(0, 0, 0, 0, 0, 0, 0);       cyc(mk(0,0,0, 32'h300,0, 1,0,1, 32'h300,0,3));
        ackd(1, 32'hBAD);               cyc(mk(0,0,0, 32'h300,0, 0,0,0, 0,0,0));
        ackd(0, 0);                     cyc(mk(0,0,0, 32'h300,0, 0,0,0, 0,0,0));
        // reset on 2nd REQ cycle
        ins(1, 1, 1, 0, 32'h400, 0, 4); cyc(mk(1,0,0, 32'h300,0, 0,0,0, 0,0,0));
        cyc(mk(1,1,0, 32'h400,0, 0,0,0, 0,0,0));
        rst_i = 1'b1;                   cyc(zero);
        rst_i = 1'b0;
        ins(0, 0, 0, 0, 0, 0, 0);
        ackd(1, 32'h55);                cyc(zero);
        ackd(0, 0);                     cyc(zero);
        // load after reset completes normally
        ins(1, 1, 1, 0, 32'h408, 0, 6); cyc(mk(1,0,0, 0,0, 0,0,0, 0,0,0));
        ackd(1, 32'hCAFEF00D);          cyc(mk(1,1,0, 32'h408,0, 0,0,0, 0,0,0));
        ackd(0, 0);                     cyc(mk(0,0,0, 32'h408,0, 0,0,0, 0,0,0));
        ins(0, 0, 0, 0, 0, 0, 0);       cyc(mk(0,0,0, 32'h408,0, 0,1,1, 32'h408,32'hCAFEF00D,6));
        cyc(mk(0,0,0, 32'h408,0, 0,0,0, 0,0,0));
        @(negedge clk_i);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage memory access unit for the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and, for loads and stores, runs a request/acknowledge transaction with a variable-latency data memory. While the access is outstanding it stalls the upstream pipeline. It then drives the MEM/WB pipeline register contents, inserting bubbles during stall cycles.

## Interface
Parameters:
- ACK_TIMEOUT, 255: maximum cycles in REQ waiting for `mem_ack_i` before the access is aborted. Range 1..255.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- RegWrite_i  in  1  EX/MEM register-write control
- MemToReg_i  in  1  EX/MEM writeback-select control
- MemRead_i  in  1  EX/MEM load request
- MemWrite_i  in  1  EX/MEM store request
- ALUresult_i  in  32  EX/MEM ALU result, used as the byte address for loads and stores
- Readdata2_i  in  32  EX/MEM store data
- INS_11_7_i  in  5  EX/MEM destination register
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = store, 0 = load
- mem_addr_o  out  32  word-aligned request address
- mem_data_o  out  32  store data
- mem_ack_i  in  1  memory completion; one-cycle pulse
- mem_data_i  in  32  load data; valid in the cycle `mem_ack_i` = 1
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- err_o  out  1  one-cycle pulse on a misaligned access or a timeout
- RegWrite_o, MemToReg_o  out  1 each  MEM/WB controls
- ALUresult_o  out  32  MEM/WB ALU result
- ReadData_o  out  32  MEM/WB load data
- INS_11_7_o  out  5  MEM/WB destination register

## Operation
- Reset: FSM goes to IDLE and every output goes to 0, including all `mem_*_o`, `stall_o`, `err_o` and all MEM/WB outputs. The timeout counter clears to 0.
- "access" means `MemRead_i | MemWrite_i`. If both are 1, the access is a store.
- Misaligned means `ALUresult_i[1:0] != 0`.
- IDLE:
  - No access: `stall_o` = 0. The MEM/WB outputs capture the inputs at the next edge, with `ReadData_o` <= 0.
  - Aligned access: `stall_o` = 1 combinationally. Latch the address, the store data and the store flag. Go to REQ.
  - Misaligned access: no request is issued. `stall_o` = 0 and `err_o` pulses in the next cycle. MEM/WB captures with `RegWrite_o` forced to 0.
- REQ:
  - `mem_enable_o` = 1 and `mem_write_o`, `mem_addr_o`, `mem_data_o` hold stable. `stall_o` = 1.
  - The counter increments every cycle.
  - `mem_ack_i` = 1: capture `mem_data_i` for a load (0 for a store), clear the counter, go to DONE.
  - Counter reaches ACK_TIMEOUT with no ack: set the abort flag, clear the counter, go to DONE.
- DONE:
  - `mem_enable_o` = 0 and `stall_o` = 0.
  - At the next edge MEM/WB captures the held EX/MEM controls, `ALUresult_i`, the captured data and `INS_11_7_i`.
  - If aborted: `RegWrite_o` <= 0 and `err_o` pulses in the next cycle.
  - Always returns to IDLE. The access is never re-issued, even though the inputs still show it.
- MEM/WB while `stall_o` = 1: bubble. `RegWrite_o`, `MemToReg_o` and `INS_11_7_o` load 0; the data fields load 0.
- `mem_ack_i` outside REQ is ignored.

## Timing
- A non-memory instruction reaches the MEM/WB outputs 1 edge after it appears on the EX/MEM inputs.
- Memory access with ack in the first REQ cycle:
  - Cycle 0: IDLE, `stall_o` = 1.
  - Cycle 1: REQ, ack sampled.
  - Cycle 2: DONE, `stall_o` = 0.
  - The result reaches MEM/WB at the end of cycle 2.
  - Total: 2 stall cycles and 3 edges of latency.
- With ack N cycles into REQ: N+1 stall cycles.
- On timeout: ACK_TIMEOUT+1 stall cycles.
- `stall_o` is combinational from state and inputs. All other outputs are registered.
- Reset asserted mid-REQ: `mem_enable_o` and `stall_o` drop immediately (asynchronously) and the transaction is discarded. An ack that arrives later is ignored.

## Test plan
- ALU op, `RegWrite_i`=1, `ALUresult_i`=0x0000_0010, `INS_11_7_i`=5, no access -> the next edge gives `RegWrite_o`=1, `ALUresult_o`=0x10, `INS_11_7_o`=5; `stall_o` never rises.
- Load at address 0x100, ack on the 3rd REQ cycle with `mem_data_i`=0xDEADBEEF:
  - `stall_o` high for 4 cycles;
  - `mem_addr_o` = 0x100 throughout REQ;
  - MEM/WB holds a bubble while stalled, then `ReadData_o`=0xDEADBEEF with `MemToReg_o`=1.
- Store of 0x12345678 to 0x204, ack on the 1st REQ cycle:
  - `mem_write_o`=1 and `mem_data_o`=0x12345678 during REQ;
  - 2 stall cycles;
  - exactly one request pulse train and no re-issue in DONE.
- Load at 0x102 -> no `mem_enable_o`, `err_o` pulses once, `RegWrite_o`=0.
- ACK_TIMEOUT=4, no ack -> 5 stall cycles, then `err_o` pulses and `RegWrite_o`=0; a stray `mem_ack_i` in IDLE has no effect.
- `rst_i` asserted on the 2nd REQ cycle -> all outputs 0 immediately. After release, the next load completes normally.
